// File: rtl/labeled_reg_reader_if.sv
// Producer write port and requester read/response handshake
// for the labeled storage reader.
interface labeled_reg_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic              w_lbl;
  logic [DATA_W-1:0] w_data;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_clr;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_lbl;
  logic              rd_denied;
  logic [7:0]        deny_cnt;

  modport master (
    output w_en, w_addr, w_lbl, w_data,
    output rd_req_valid, rd_addr, rd_clr,
    output rd_resp_ready,
    input  rd_req_ready, rd_resp_valid,
    input  rd_data, rd_lbl, rd_denied, deny_cnt
  );

  modport slave (
    input  w_en, w_addr, w_lbl, w_data,
    input  rd_req_valid, rd_addr, rd_clr,
    input  rd_resp_ready,
    output rd_req_ready, rd_resp_valid,
    output rd_data, rd_lbl, rd_denied, deny_cnt
  );
endinterface

// File: rtl/labeled_reg_reader.sv
// Label-filtered register bank reader: H entries are never
// returned to an L requester; denied reads are counted.
module labeled_reg_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input logic clk,
  input logic rst,
  labeled_reg_reader_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              clr_q;
  logic [DATA_W-1:0] data_q;
  logic              lbl_q;
  logic              den_q;
  logic [7:0]        cnt;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_lbl  [DEPTH];

  logic deny;
  logic in_resp;

  assign deny    = mem_lbl[addr_q] & ~clr_q;
  assign in_resp = (state == RESP);

  // Label and data share one write so they can never diverge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_lbl[i]  <= 1'b0;
      end
    end else if (bus.w_en) begin
      mem_data[bus.w_addr] <= bus.w_data;
      mem_lbl[bus.w_addr]  <= bus.w_lbl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      clr_q  <= 1'b0;
      data_q <= '0;
      lbl_q  <= 1'b0;
      den_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.rd_req_valid) begin
            addr_q <= bus.rd_addr;
            clr_q  <= bus.rd_clr;
            state  <= LOOKUP;
          end
        end
        (state == LOOKUP): begin
          lbl_q  <= mem_lbl[addr_q];
          den_q  <= deny;
          data_q <= deny ? '0 : mem_data[addr_q];
          if (deny && cnt != 8'hFF)
            cnt <= cnt + 8'd1;
          state <= RESP;
        end
        (state == RESP): begin
          if (bus.rd_resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response fields are forced to zero outside RESP so nothing stale leaks.
  assign bus.rd_req_ready  = (state == IDLE);
  assign bus.rd_resp_valid = in_resp;
  assign bus.rd_data       = in_resp ? data_q : '0;
  assign bus.rd_lbl        = in_resp & lbl_q;
  assign bus.rd_denied     = in_resp & den_q;
  assign bus.deny_cnt      = cnt;
endmodule

// File: tb/tb_labeled_reg_reader.sv
// Self-checking bench for labeled_reg_reader against a
// label/clearance reference model of the entry bank.
module tb_labeled_reg_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  labeled_reg_reader_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  labeled_reg_reader #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_data [4];
  logic       m_lbl  [4];
  int         m_cnt;

  logic       e_lbl;
  logic       e_den;
  logic [7:0] e_dat;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 8'h00;
      m_lbl[i]  = 1'b0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_read(input logic [1:0] a, input logic c);
    e_lbl = m_lbl[a];
    e_den = m_lbl[a] & ~c;
    e_dat = e_den ? 8'h00 : m_data[a];
    if (e_den && m_cnt < 255) m_cnt++;
  endfunction

  task automatic wr(input logic [1:0] a, input logic l, input logic [7:0] d);
    bus.w_en = 1'b1; bus.w_addr = a; bus.w_lbl = l; bus.w_data = d;
    tick();
    bus.w_en = 1'b0;
    m_lbl[a] = l; m_data[a] = d;
  endtask

  task automatic accept(input logic [1:0] a, input logic c);
    bus.rd_req_valid = 1'b1; bus.rd_addr = a; bus.rd_clr = c;
    tick();
    bus.rd_req_valid = 1'b0;
  endtask

  task automatic release_resp();
    bus.rd_resp_ready = 1'b1;
    tick();
    bus.rd_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_clear();
    n_tests++;
    if ({bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied,
         bus.rd_data, bus.deny_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state got rr=%b rv=%b l=%b d=%b data=%h cnt=%h want 1 0 0 0 00 00",
               bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied,
               bus.rd_data, bus.deny_cnt);
    end
  endtask

  task automatic test_basic();
    wr(2'd1, 1'b0, 8'hA5);
    accept(2'd1, 1'b0);
    model_read(2'd1, 1'b0);
    n_tests++;
    if ({bus.rd_resp_valid, bus.rd_req_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_lookup got rv=%b rr=%b want 0 0", bus.rd_resp_valid, bus.rd_req_ready);
    end
    tick();
    n_tests++;
    if ({bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data}
        !== {1'b1, e_lbl, e_den, e_dat}) begin
      n_fail++;
      $display("FAIL basic_resp got rv=%b l=%b d=%b data=%h want 1 %b %b %h",
               bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data, e_lbl, e_den, e_dat);
    end
    release_resp();
    n_tests++;
    if ({bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL basic_idle got rr=%b rv=%b l=%b d=%b data=%h want 1 0 0 0 00",
               bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data);
    end
  endtask

  task automatic test_label();
    logic c;
    wr(2'd2, 1'b1, 8'h3C);
    for (int k = 0; k < 2; k++) begin
      c = (k == 1);
      accept(2'd2, c);
      model_read(2'd2, c);
      tick();
      n_tests++;
      if ({bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data, bus.deny_cnt}
          !== {1'b1, e_lbl, e_den, e_dat, m_cnt[7:0]}) begin
        n_fail++;
        $display("FAIL label_clr%0b got rv=%b l=%b d=%b data=%h cnt=%0d want 1 %b %b %h %0d",
                 c, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data,
                 bus.deny_cnt, e_lbl, e_den, e_dat, m_cnt);
      end
      release_resp();
    end
  endtask

  task automatic test_collision();
    wr(2'd3, 1'b1, 8'h77);
    accept(2'd3, 1'b0);
    model_read(2'd3, 1'b0);
    bus.w_en = 1'b1; bus.w_addr = 2'd3; bus.w_lbl = 1'b0; bus.w_data = 8'h11;
    tick();
    bus.w_en = 1'b0;
    m_lbl[3] = 1'b0; m_data[3] = 8'h11;
    n_tests++;
    if ({bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data}
        !== {1'b1, e_lbl, e_den, e_dat}) begin
      n_fail++;
      $display("FAIL collide_lookup got rv=%b l=%b d=%b data=%h want 1 %b %b %h",
               bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data, e_lbl, e_den, e_dat);
    end
    wr(2'd3, 1'b1, 8'h99);
    n_tests++;
    if ({bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data}
        !== {1'b1, e_lbl, e_den, e_dat}) begin
      n_fail++;
      $display("FAIL collide_held got rv=%b l=%b d=%b data=%h want 1 %b %b %h",
               bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data, e_lbl, e_den, e_dat);
    end
    release_resp();
    bus.w_en = 1'b1; bus.w_addr = 2'd0; bus.w_lbl = 1'b1; bus.w_data = 8'h5A;
    bus.rd_req_valid = 1'b1; bus.rd_addr = 2'd0; bus.rd_clr = 1'b1;
    tick();
    bus.w_en = 1'b0; bus.rd_req_valid = 1'b0;
    m_lbl[0] = 1'b1; m_data[0] = 8'h5A;
    model_read(2'd0, 1'b1);
    tick();
    n_tests++;
    if ({bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data}
        !== {1'b1, e_lbl, e_den, e_dat}) begin
      n_fail++;
      $display("FAIL collide_accept got rv=%b l=%b d=%b data=%h want 1 %b %b %h",
               bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data, e_lbl, e_den, e_dat);
    end
    release_resp();
  endtask

  task automatic test_backpressure();
    logic [1:0] a;
    logic       c;
    a = 2'($urandom_range(0, 3));
    c = 1'($urandom_range(0, 1));
    accept(a, c);
    model_read(a, c);
    tick();
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if ({bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data}
          !== {1'b0, 1'b1, e_lbl, e_den, e_dat}) begin
        n_fail++;
        $display("FAIL stall_%0d got rr=%b rv=%b l=%b d=%b data=%h want 0 1 %b %b %h",
                 k, bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied,
                 bus.rd_data, e_lbl, e_den, e_dat);
      end
      tick();
    end
    release_resp();
    n_tests++;
    if ({bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL stall_release got rr=%b rv=%b l=%b d=%b data=%h want 1 0 0 0 00",
               bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    int n_rr = 0;
    int n_rv = 0;
    logic [7:0] want;
    want = m_lbl[1] ? 8'h00 : m_data[1];
    bus.rd_req_valid = 1'b1; bus.rd_addr = 2'd1; bus.rd_clr = 1'b0;
    bus.rd_resp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.rd_req_ready) n_rr++;
      if (bus.rd_resp_valid) begin
        n_rv++;
        model_read(2'd1, 1'b0);
        n_tests++;
        if (bus.rd_data !== want) begin
          n_fail++;
          $display("FAIL b2b_data got %h want %h", bus.rd_data, want);
        end
      end
      tick();
    end
    bus.rd_req_valid = 1'b0; bus.rd_resp_ready = 1'b0;
    n_tests++;
    if (n_rr != 4 || n_rv != 4) begin
      n_fail++;
      $display("FAIL b2b_rate got ready=%0d resp=%0d in 12 cycles want 4 4", n_rr, n_rv);
    end
  endtask

  task automatic test_random();
    logic [1:0] a;
    logic       c;
    int         hold;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1)
        wr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
      a = 2'($urandom_range(0, 3));
      c = 1'($urandom_range(0, 1));
      accept(a, c);
      model_read(a, c);
      tick();
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) tick();
      n_tests++;
      if ({bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data, bus.deny_cnt}
          !== {1'b1, e_lbl, e_den, e_dat, m_cnt[7:0]}) begin
        n_fail++;
        $display("FAIL rand_%0d a=%0d c=%b got rv=%b l=%b d=%b data=%h cnt=%0d want 1 %b %b %h %0d",
                 k, a, c, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data,
                 bus.deny_cnt, e_lbl, e_den, e_dat, m_cnt);
      end
      release_resp();
    end
  endtask

  task automatic test_saturate();
    wr(2'd2, 1'b1, 8'($urandom));
    for (int k = 0; k < 300; k++) begin
      accept(2'd2, 1'b0);
      model_read(2'd2, 1'b0);
      tick();
      release_resp();
      if (k == 100) begin
        n_tests++;
        if (bus.deny_cnt !== m_cnt[7:0]) begin
          n_fail++;
          $display("FAIL sat_mid got %0d want %0d", bus.deny_cnt, m_cnt);
        end
      end
    end
    n_tests++;
    if (bus.deny_cnt !== m_cnt[7:0]) begin
      n_fail++;
      $display("FAIL sat_final got %0d want %0d", bus.deny_cnt, m_cnt);
    end
  endtask

  task automatic test_reset_in_resp();
    accept(2'd2, 1'b1);
    model_read(2'd2, 1'b1);
    tick();
    rst = 1'b1;
    bus.w_en = 1'b1; bus.w_addr = 2'd1; bus.w_lbl = 1'b1; bus.w_data = 8'hFF;
    tick();
    rst = 1'b0;
    bus.w_en = 1'b0;
    model_clear();
    n_tests++;
    if ({bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied,
         bus.rd_data, bus.deny_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_resp got rr=%b rv=%b l=%b d=%b data=%h cnt=%h want 1 0 0 0 00 00",
               bus.rd_req_ready, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied,
               bus.rd_data, bus.deny_cnt);
    end
    for (int a = 0; a < 4; a++) begin
      accept(2'(a), 1'b1);
      model_read(2'(a), 1'b1);
      tick();
      n_tests++;
      if ({bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data}
          !== {1'b1, e_lbl, e_den, e_dat}) begin
        n_fail++;
        $display("FAIL rst_entry%0d got rv=%b l=%b d=%b data=%h want 1 %b %b %h",
                 a, bus.rd_resp_valid, bus.rd_lbl, bus.rd_denied, bus.rd_data,
                 e_lbl, e_den, e_dat);
      end
      release_resp();
    end
  endtask

  initial begin
    bus.w_en = 1'b0; bus.w_addr = '0; bus.w_lbl = 1'b0; bus.w_data = '0;
    bus.rd_req_valid = 1'b0; bus.rd_addr = '0; bus.rd_clr = 1'b0;
    bus.rd_resp_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_label();
    test_collision();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_in_resp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
